tm1638_frame_sequencer: RTL and testbench

//  Frame-level controller for the tm1638 byte engine. Each frame runs a 4-byte key scan, a

---
 rtl/tm1638_frame_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_tm1638_frame_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_sequencer.sv
// Frame-level controller for the tm1638 byte engine: key scan, write-mode command,
// 16-byte auto-increment display write and display control, driven from input snapshots.
module tm1638_frame_sequencer #(
    parameter int AUTO_REFRESH = 1,
    parameter int REFRESH_CYC  = 524288,
    parameter int CS_GAP       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] seg_data,
    input  logic [7:0]  led_data,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic [7:0]  keys,
    output logic        keys_valid,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        tm_cs,
    output logic        tm_rw,
    output logic        tm_latch,
    output logic [7:0]  tm_out,
    input  logic [7:0]  tm_in,
    input  logic        tm_busy
);
    localparam int TW = $clog2(REFRESH_CYC + 1);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_CYC - 1);
    localparam logic [GW-1:0] GAP_RELOAD   = GW'(CS_GAP - 1);
    localparam bit AUTO_EN = (AUTO_REFRESH != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_LOW,
        ST_ISSUE,
        ST_ACK,
        ST_DONE,
        ST_CS_HIGH
    } state_t;

    state_t          state_r;
    logic [1:0]      txn_r;
    logic [4:0]      byte_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [TW-1:0]   timer_r;
    logic            pending_r;
    logic [63:0]     seg_snap_r;
    logic [7:0]      led_snap_r;
    logic [3:0]      ctrl_snap_r;
    logic [7:0]      key_shadow_r;

    logic [7:0]      tx_byte_s;
    logic [4:0]      last_idx_s;
    logic [4:0]      idx_m1_s;
    logic [2:0]      digit_s;
    logic [7:0]      key_merge_s;
    logic            frame_go_s;

    // Read byte n carries key S(n+1) in bit 0 and key S(n+5) in bit 4.
    function automatic logic [7:0] merge_keys(input logic [7:0] cur, input logic [1:0] n,
                                              input logic [7:0] rx);
        logic [7:0] res;
        res = cur;
        res[3'd7 - {1'b0, n}] = rx[0];
        res[3'd3 - {1'b0, n}] = rx[4];
        return res;
    endfunction

    // Byte to transmit and last byte index for the current transaction.
    always_comb begin
        tx_byte_s  = 8'h00;
        last_idx_s = 5'd0;
        idx_m1_s   = byte_r - 5'd1;
        digit_s    = idx_m1_s[3:1];
        case (txn_r)
            2'd0: begin
                last_idx_s = 5'd4;
                if (byte_r == 5'd0) tx_byte_s = 8'h42;
                else                tx_byte_s = 8'h00;
            end
            2'd1: begin
                last_idx_s = 5'd0;
                tx_byte_s  = 8'h40;
            end
            2'd2: begin
                last_idx_s = 5'd16;
                // after the address byte, odd indices are digits and even indices are LEDs
                if (byte_r == 5'd0)  tx_byte_s = 8'hC0;
                else if (byte_r[0])  tx_byte_s = seg_snap_r[{3'd7 - digit_s, 3'b000} +: 8];
                else                 tx_byte_s = {7'b0000000, led_snap_r[3'd7 - digit_s]};
            end
            2'd3: begin
                last_idx_s = 5'd0;
                tx_byte_s  = 8'h80 | {4'b0000, ctrl_snap_r};
            end
            default: begin
                last_idx_s = 5'd0;
                tx_byte_s  = 8'h00;
            end
        endcase
    end

    // Key shadow merge and frame launch condition.
    always_comb begin
        key_merge_s = merge_keys(key_shadow_r, idx_m1_s[1:0], tm_in);
        if ((gap_cnt_r == {GW{1'b0}}) &&
            (start || pending_r || (AUTO_EN && (timer_r == {TW{1'b0}}))))
            frame_go_s = 1'b1;
        else
            frame_go_s = 1'b0;
    end

    // Frame sequencer: transaction/byte walk with latch-ack-done handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            txn_r        <= 2'd0;
            byte_r       <= 5'd0;
            gap_cnt_r    <= {GW{1'b0}};
            timer_r      <= TIMER_RELOAD;
            pending_r    <= 1'b0;
            seg_snap_r   <= 64'h0;
            led_snap_r   <= 8'h00;
            ctrl_snap_r  <= 4'h0;
            key_shadow_r <= 8'h00;
            keys         <= 8'h00;
            keys_valid   <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            tm_cs        <= 1'b1;
            tm_rw        <= 1'b1;
            tm_latch     <= 1'b0;
            tm_out       <= 8'h00;
        end else begin
            tm_latch   <= 1'b0;
            keys_valid <= 1'b0;
            frame_done <= 1'b0;
            if (start) pending_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (gap_cnt_r != {GW{1'b0}}) gap_cnt_r <= gap_cnt_r - GW'(1);
                    if (timer_r != {TW{1'b0}})   timer_r   <= timer_r - TW'(1);
                    if (frame_go_s) begin
                        pending_r   <= 1'b0;
                        frame_busy  <= 1'b1;
                        seg_snap_r  <= seg_data;
                        led_snap_r  <= led_data;
                        ctrl_snap_r <= {display_on, brightness};
                        txn_r       <= 2'd0;
                        byte_r      <= 5'd0;
                        state_r     <= ST_CS_LOW;
                    end
                end
                ST_CS_LOW: begin
                    if (!tm_busy) begin
                        tm_cs   <= 1'b0;
                        tm_rw   <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!tm_busy) begin
                        tm_latch <= 1'b1;
                        tm_out   <= tx_byte_s;
                        state_r  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (tm_busy) state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (!tm_busy) begin
                        if ((txn_r == 2'd0) && (byte_r != 5'd0)) key_shadow_r <= key_merge_s;
                        if (byte_r == last_idx_s) begin
                            tm_cs     <= 1'b1;
                            gap_cnt_r <= GAP_RELOAD;
                            state_r   <= ST_CS_HIGH;
                            if (txn_r == 2'd0) begin
                                keys       <= key_merge_s;
                                keys_valid <= 1'b1;
                            end
                        end else begin
                            byte_r  <= byte_r + 5'd1;
                            state_r <= ST_ISSUE;
                            if ((txn_r == 2'd0) && (byte_r == 5'd0)) tm_rw <= 1'b0;
                        end
                    end
                end
                ST_CS_HIGH: begin
                    if (gap_cnt_r != {GW{1'b0}}) begin
                        gap_cnt_r <= gap_cnt_r - GW'(1);
                    end else if (txn_r == 2'd3) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        timer_r    <= TIMER_RELOAD;
                        gap_cnt_r  <= GAP_RELOAD;
                        state_r    <= ST_IDLE;
                    end else begin
                        txn_r   <= txn_r + 2'd1;
                        byte_r  <= 5'd0;
                        state_r <= ST_CS_LOW;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Bench for tm1638_frame_sequencer: byte-engine model, table vectors, random frames against
// a frame-level reference model, plus start-queueing, mid-frame reset and auto-refresh sequences.
`timescale 1ns/1ps
module tb_tm1638_frame_sequencer;
    localparam int CS_GAP   = 4;
    localparam int REFRESH  = 100;
    localparam int BUSY_LEN = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst1 = 1'b1;
    logic        start0 = 1'b0;
    logic [63:0] seg0 = 64'h0;
    logic [7:0]  led0 = 8'h00;
    logic [2:0]  br0 = 3'd0;
    logic        on0 = 1'b0;
    logic [7:0]  keys0, out0;
    logic        kv0, fbusy0, fdone0, cs0, rw0, latch0;
    logic [7:0]  in0 = 8'h00;
    logic        ebusy0 = 1'b0;

    logic        start1 = 1'b0;
    logic [7:0]  keys1, out1;
    logic        kv1, fbusy1, fdone1, cs1, rw1, latch1;
    logic        ebusy1 = 1'b0;

    tm1638_frame_sequencer #(.AUTO_REFRESH(0), .REFRESH_CYC(16), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst), .start(start0), .seg_data(seg0), .led_data(led0),
        .brightness(br0), .display_on(on0), .keys(keys0), .keys_valid(kv0),
        .frame_busy(fbusy0), .frame_done(fdone0), .tm_cs(cs0), .tm_rw(rw0),
        .tm_latch(latch0), .tm_out(out0), .tm_in(in0), .tm_busy(ebusy0));

    tm1638_frame_sequencer #(.AUTO_REFRESH(1), .REFRESH_CYC(REFRESH), .CS_GAP(CS_GAP)) dut_auto (
        .clk(clk), .rst(rst1), .start(start1), .seg_data(64'h0123456789ABCDEF), .led_data(8'h5A),
        .brightness(3'd4), .display_on(1'b1), .keys(keys1), .keys_valid(kv1),
        .frame_busy(fbusy1), .frame_done(fdone1), .tm_cs(cs1), .tm_rw(rw1),
        .tm_latch(latch1), .tm_out(out1), .tm_in(8'h00), .tm_busy(ebusy1));

    typedef struct {
        logic [63:0]      seg;
        logic [7:0]       led;
        logic [2:0]       br;
        logic             on;
        logic [3:0][7:0]  rd;
        logic [7:0]       exp_keys;
        logic [7:0]       exp_ctrl;
    } vec_t;
    typedef logic [7:0] bytes24_t [24];

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    logic [7:0] log0 [$];
    logic       logrw0 [$];
    logic [3:0][7:0] rd_arr = 32'h0;
    int  e0_cnt = 0, rd_total = 0, cs_falls0 = 0, viol0 = 0, kv_cnt0 = 0, glitch0 = 0;
    logic e0_rd = 1'b0, cs_prev0 = 1'b1, latch_prev0 = 1'b0;
    logic [7:0] e0_rdata = 8'h00, keys_prev0 = 8'h00;
    int  e1_cnt = 0, viol1 = 0;
    logic latch_prev1 = 1'b0, fbusy1_prev = 1'b0;
    int  d1_q [$];
    int  r1_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Byte engine for the start-driven sequencer: busy one clock after latch, BUSY_LEN clocks long.
    always @(posedge clk) begin
        cs_prev0    <= cs0;
        latch_prev0 <= latch0;
        if (cs_prev0 && !cs0) cs_falls0 <= cs_falls0 + 1;
        if (latch0 && (ebusy0 || latch_prev0 || cs0)) viol0 <= viol0 + 1;
        if (latch0 && !ebusy0) begin
            log0.push_back(out0);
            logrw0.push_back(rw0);
            ebusy0 <= 1'b1;
            e0_cnt <= BUSY_LEN;
            e0_rd  <= !rw0;
            if (!rw0) begin
                e0_rdata <= rd_arr[rd_total % 4];
                rd_total <= rd_total + 1;
            end
        end else if (e0_cnt > 1) begin
            e0_cnt <= e0_cnt - 1;
        end else if (e0_cnt == 1) begin
            e0_cnt <= 0;
            ebusy0 <= 1'b0;
            if (e0_rd) in0 <= e0_rdata;
        end
    end

    // Byte engine for the auto-refresh sequencer.
    always @(posedge clk) begin
        latch_prev1 <= latch1;
        if (latch1 && (ebusy1 || latch_prev1)) viol1 <= viol1 + 1;
        if (latch1 && !ebusy1) begin
            ebusy1 <= 1'b1;
            e1_cnt <= BUSY_LEN;
        end else if (e1_cnt > 1) begin
            e1_cnt <= e1_cnt - 1;
        end else if (e1_cnt == 1) begin
            e1_cnt <= 0;
            ebusy1 <= 1'b0;
        end
    end

    // Output monitors sampled on the falling edge.
    always @(negedge clk) begin
        keys_prev0  <= keys0;
        fbusy1_prev <= fbusy1;
        if (!rst && !kv0 && (keys0 !== keys_prev0)) glitch0 <= glitch0 + 1;
        if (kv0) kv_cnt0 <= kv_cnt0 + 1;
        if (fdone1) d1_q.push_back(cyc);
        if (fbusy1 && !fbusy1_prev) r1_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_frame(input logic [63:0] seg, input logic [7:0] led,
                                        input logic [2:0] br, input logic on,
                                        output bytes24_t b, output logic [23:0] rw);
        for (int k = 0; k < 24; k++) b[k] = 8'h00;
        rw = 24'hFFFFFF;
        for (int n = 1; n <= 4; n++) rw[n] = 1'b0;
        b[0] = 8'h42;
        b[5] = 8'h40;
        b[6] = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            b[7 + 2*i] = 8'((seg >> (8*(7-i))) & 64'hFF);
            b[8 + 2*i] = {7'b0000000, led[7-i]};
        end
        b[23] = 8'h80 + (on ? 8'd8 : 8'd0) + {5'b00000, br};
    endfunction

    function automatic logic [7:0] model_keys(input logic [3:0][7:0] rd);
        logic [7:0] k;
        k = 8'h00;
        for (int n = 0; n < 4; n++) begin
            k[7-n] = rd[n][0];
            k[3-n] = rd[n][4];
        end
        return k;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fdone0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_frame(input string tag, input logic [63:0] seg, input logic [7:0] led,
                            input logic [2:0] br, input logic on, input logic [3:0][7:0] rd,
                            input bit perturb, output int base);
        int cs_base, kv_base, got;
        bit ok;
        bytes24_t exp_b;
        logic [23:0] exp_rw;
        rd_arr = rd;
        seg0 = seg; led0 = led; br0 = br; on0 = on;
        base = log0.size(); cs_base = cs_falls0; kv_base = kv_cnt0;
        pulse_start();
        if (perturb) begin
            repeat ($urandom_range(20, 800)) @(negedge clk);
            seg0 = {$urandom, $urandom}; led0 = 8'($urandom); br0 = 3'($urandom); on0 = ~on;
        end
        wait_done(3000, ok);
        chk({tag, " frame_done"}, 64'(ok), 64'd1);
        model_frame(seg, led, br, on, exp_b, exp_rw);
        got = log0.size() - base;
        chk({tag, " latch count"}, 64'(got), 64'd24);
        for (int k = 0; k < 24; k++) begin
            if (k < got) begin
                chk($sformatf("%s byte%0d", tag, k), 64'(log0[base+k]), 64'(exp_b[k]));
                chk($sformatf("%s rw%0d", tag, k), 64'(logrw0[base+k]), 64'(exp_rw[k]));
            end
        end
        chk({tag, " cs windows"}, 64'(cs_falls0 - cs_base), 64'd4);
        chk({tag, " keys_valid pulses"}, 64'(kv_cnt0 - kv_base), 64'd1);
        chk({tag, " keys"}, 64'(keys0), 64'(model_keys(rd)));
        chk({tag, " busy low after done"}, 64'(fbusy0), 64'd0);
    endtask

    initial begin
        vec_t vecs [5];
        int base, gap, rises;
        bit ok, latch_seen;

        vecs[0] = '{seg: 64'h065B4F666D7D077F, led: 8'hA5, br: 3'd7, on: 1'b1,
                    rd: 32'h01_10_00_11, exp_keys: 8'h9A, exp_ctrl: 8'h8F};
        vecs[1] = '{seg: 64'h0123456789ABCDEF, led: 8'h3C, br: 3'd0, on: 1'b0,
                    rd: 32'hFF_FF_FF_FF, exp_keys: 8'hFF, exp_ctrl: 8'h80};
        vecs[2] = '{seg: 64'hFFFFFFFFFFFFFFFF, led: 8'h00, br: 3'd3, on: 1'b1,
                    rd: 32'h00_00_00_01, exp_keys: 8'h80, exp_ctrl: 8'h8B};
        vecs[3] = '{seg: 64'h0000000000000000, led: 8'hFF, br: 3'd5, on: 1'b0,
                    rd: 32'h10_00_00_00, exp_keys: 8'h01, exp_ctrl: 8'h85};
        vecs[4] = '{seg: 64'h8080808080808080, led: 8'h81, br: 3'd2, on: 1'b1,
                    rd: 32'h00_10_01_00, exp_keys: 8'h42, exp_ctrl: 8'h8A};

        repeat (3) @(negedge clk);
        chk("reset tm_cs", 64'(cs0), 64'd1);
        chk("reset tm_rw", 64'(rw0), 64'd1);
        chk("reset tm_latch", 64'(latch0), 64'd0);
        chk("reset tm_out", 64'(out0), 64'd0);
        chk("reset keys", 64'(keys0), 64'd0);
        chk("reset keys_valid", 64'(kv0), 64'd0);
        chk("reset frame_busy", 64'(fbusy0), 64'd0);
        chk("reset frame_done", 64'(fdone0), 64'd0);
        rst = 1'b0; rst1 = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_frame($sformatf("vec%0d", v), vecs[v].seg, vecs[v].led, vecs[v].br,
                     vecs[v].on, vecs[v].rd, 1'b0, base);
            chk($sformatf("vec%0d table keys", v), 64'(keys0), 64'(vecs[v].exp_keys));
            chk($sformatf("vec%0d table ctrl", v), 64'(log0[base+23]), 64'(vecs[v].exp_ctrl));
        end

        for (int r = 0; r < 4; r++) begin
            do_frame($sformatf("rand%0d", r), {$urandom, $urandom}, 8'($urandom), 3'($urandom),
                     1'($urandom), {$urandom}, 1'b1, base);
        end

        // several starts during a frame queue exactly one follow-on frame
        rd_arr = vecs[0].rd;
        seg0 = vecs[0].seg; led0 = vecs[0].led; br0 = vecs[0].br; on0 = vecs[0].on;
        base = log0.size();
        pulse_start();
        repeat (50) @(negedge clk);
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        repeat (300) @(negedge clk);
        pulse_start();
        wait_done(3000, ok);
        chk("pending first done", 64'(ok), 64'd1);
        gap = 0;
        while (!fbusy0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        chk("pending follow-on started", 64'(fbusy0), 64'd1);
        chk("pending gap >= CS_GAP", 64'(gap >= CS_GAP), 64'd1);
        wait_done(3000, ok);
        chk("pending second done", 64'(ok), 64'd1);
        rises = 0;
        repeat (300) begin
            @(negedge clk);
            if (fbusy0) rises++;
        end
        chk("pending no third frame", 64'(rises), 64'd0);
        chk("pending latch total", 64'(log0.size() - base), 64'd48);

        // reset while the sixth T3 byte is being latched
        base = log0.size();
        pulse_start();
        for (int i = 0; i < 3000 && log0.size() < base + 11; i++) @(negedge clk);
        latch_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (latch0) begin
                latch_seen = 1'b1;
                break;
            end
        end
        chk("midreset latch observed", 64'(latch_seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset tm_cs", 64'(cs0), 64'd1);
        chk("midreset tm_latch", 64'(latch0), 64'd0);
        chk("midreset frame_busy", 64'(fbusy0), 64'd0);
        chk("midreset stage", 64'(log0.size() - base), 64'd11);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        do_frame("after reset", vecs[4].seg, vecs[4].led, vecs[4].br, vecs[4].on,
                 vecs[4].rd, 1'b0, base);

        chk("latch protocol violations", 64'(viol0), 64'd0);
        chk("keys changed outside keys_valid", 64'(glitch0), 64'd0);

        chk("auto frames seen", 64'(d1_q.size() >= 3 && r1_q.size() >= 3), 64'd1);
        for (int k = 1; k < 3; k++) begin
            if (k < d1_q.size() && k < r1_q.size()) begin
                chk($sformatf("auto restart delay %0d", k), 64'(r1_q[k] - d1_q[k-1]), 64'(REFRESH));
                chk($sformatf("auto done spacing %0d", k), 64'(d1_q[k] - d1_q[k-1]),
                    64'((d1_q[k] - r1_q[k]) + REFRESH));
            end
        end
        chk("auto latch while busy", 64'(viol1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
